// File: rtl/bk_pkg.sv
// Shared definitions for the Brent-Kung adder family.
// Provides:
//   gp_t      - packed (generate, propagate) pair for one bit or bit group
//   clog2     - ceiling log2, used to size the prefix tree levels
//   gp_merge  - associative group operator: (hi) o (lo)
package bk_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Combine a more-significant group (hi) with the adjacent less-significant
  // group (lo) into one group spanning both.
  function automatic gp_t gp_merge(input gp_t hi, input gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage

// File: rtl/bk_prefix_core.sv
// Combinational Brent-Kung prefix network, split into its two sweeps so the
// instantiating block can place a register between them.
// Ports:
//   bit_gp    in   per-bit (g,p) from the operands
//   up_gp     out  up-sweep result: position i holds the group ending at i
//                  whose span is set by the largest power of two dividing i+1
//   dn_in_gp  in   up-sweep result (possibly registered) fed to the down-sweep
//   prefix_gp out  position i holds the group (G,P) spanning bits [0..i]
module bk_prefix_core
  import bk_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  gp_t [WIDTH-1:0] bit_gp,
  output gp_t [WIDTH-1:0] up_gp,
  input  gp_t [WIDTH-1:0] dn_in_gp,
  output gp_t [WIDTH-1:0] prefix_gp
);

  localparam int UP_LVLS = clog2(WIDTH);
  localparam int DN_LVLS = UP_LVLS - 1;

  // Up-sweep: at level l, every position i with (i+1) a multiple of 2^l
  // absorbs the group ending 2^(l-1) positions below it.
  for (genvar l = 0; l <= UP_LVLS; l++) begin : g_up
    gp_t [WIDTH-1:0] node;
    if (l == 0) begin : g_leaf
      assign node = bit_gp;
    end else begin : g_lvl
      localparam int HALF = 1 << (l - 1);
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (((i + 1) % (2 * HALF)) == 0) begin : g_m
          assign node[i] = gp_merge(g_up[l-1].node[i], g_up[l-1].node[i-HALF]);
        end else begin : g_pass
          assign node[i] = g_up[l-1].node[i];
        end
      end
    end
  end

  assign up_gp = g_up[UP_LVLS].node;

  // Down-sweep: from coarse to fine stride, each position sitting half a
  // stride above a completed prefix extends itself down to bit 0.
  for (genvar k = 0; k <= DN_LVLS; k++) begin : g_dn
    gp_t [WIDTH-1:0] node;
    if (k == 0) begin : g_root
      assign node = dn_in_gp;
    end else begin : g_lvl
      localparam int HALF = 1 << (UP_LVLS - k - 1);
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if ((((i + 1) % (2 * HALF)) == HALF) && ((i + 1) > HALF)) begin : g_m
          assign node[i] = gp_merge(g_dn[k-1].node[i], g_dn[k-1].node[i-HALF]);
        end else begin : g_pass
          assign node[i] = g_dn[k-1].node[i];
        end
      end
    end
  end

  assign prefix_gp = g_dn[DN_LVLS].node;

endmodule

// File: rtl/bk_pipe_addsub.sv
// Pipelined Brent-Kung adder/subtractor with valid/ready flow control.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake; accepted when both are high
//   in_a, in_b            operands
//   in_cin                carry-in (add mode only)
//   in_sub                0 = a+b+cin, 1 = a-b
//   in_tag                sideband tag carried with the operation
//   out_valid / out_ready output handshake
//   out_sum               result modulo 2^WIDTH
//   out_cout              carry out of MSB (sub: 1 = no borrow)
//   out_ovf               signed overflow
//   out_zero              out_sum == 0
//   out_tag               tag of this result
// Register placement: PIPE_STAGES=1 output only; 2 adds a register between
// the sweeps; 3 adds another after bitwise g/p generation.
module bk_pipe_addsub
  import bk_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int LAST = PIPE_STAGES - 1;
  localparam int MID  = (PIPE_STAGES >= 2) ? PIPE_STAGES - 2 : 0;

  // ---------------- valid chain ----------------
  logic [PIPE_STAGES-1:0] v_q, v_d, adv, ld, src_v;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    logic full;
    adv   = '0;
    ld    = '0;
    src_v = '0;
    v_d   = v_q;
    src_v[0] = in_valid;
    for (int k = 1; k < PIPE_STAGES; k++) src_v[k] = v_q[k-1];
    for (int k = 0; k < PIPE_STAGES; k++) begin
      // Stage k moves unless it and every stage after it is full and the
      // consumer is stalling.
      full = 1'b1;
      for (int j = k; j < PIPE_STAGES; j++) full = full & v_q[j];
      adv[k] = out_ready | ~full;
      ld[k]  = adv[k] & src_v[k];
      if (adv[k]) v_d[k] = src_v[k];
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) v_q <= '0;
    else        v_q <= v_d;
  end

  assign in_ready  = adv[0];
  assign out_valid = v_q[LAST];

  // ---------------- bitwise g/p ----------------
  gp_t [WIDTH-1:0] gen_gp_d;
  logic            gen_c0_d;
  logic [WIDTH-1:0] b_eff;

  always_comb begin
    b_eff    = in_sub ? ~in_b : in_b;
    gen_c0_d = in_sub | in_cin;
    for (int i = 0; i < WIDTH; i++)
      gen_gp_d[i] = '{g: in_a[i] & b_eff[i], p: in_a[i] ^ b_eff[i]};
  end

  gp_t [WIDTH-1:0]  up_in_gp;
  logic             up_c0;
  logic [TAG_W-1:0] up_tag;

  if (PIPE_STAGES == 3) begin : g_gen_reg
    gp_t [WIDTH-1:0]  gen_gp_q;
    logic             gen_c0_q;
    logic [TAG_W-1:0] gen_tag_q;
    // NOTE: datapath registers are reset along with the valid bits; the
    // cost is small and it keeps simulation free of X on idle stages.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        gen_gp_q  <= '0;
        gen_c0_q  <= 1'b0;
        gen_tag_q <= '0;
      end else if (ld[0]) begin
        gen_gp_q  <= gen_gp_d;
        gen_c0_q  <= gen_c0_d;
        gen_tag_q <= in_tag;
      end
    end
    assign up_in_gp = gen_gp_q;
    assign up_c0    = gen_c0_q;
    assign up_tag   = gen_tag_q;
  end else begin : g_gen_thru
    assign up_in_gp = gen_gp_d;
    assign up_c0    = gen_c0_d;
    assign up_tag   = in_tag;
  end

  // ---------------- prefix network ----------------
  gp_t [WIDTH-1:0] up_gp, dn_gp, prefix_gp;

  bk_prefix_core #(.WIDTH(WIDTH)) u_core (
    .bit_gp    (up_in_gp),
    .up_gp     (up_gp),
    .dn_in_gp  (dn_gp),
    .prefix_gp (prefix_gp)
  );

  gp_t [WIDTH-1:0]  mid_gp_d;
  logic [WIDTH-1:0] mid_p_d;
  logic [WIDTH-1:0] dn_p;
  logic             dn_c0;
  logic [TAG_W-1:0] dn_tag;

  // Bit-level propagate must survive the sweep register separately: the
  // up-sweep overwrites p at odd positions with group propagates.
  always_comb begin
    mid_gp_d = up_gp;
    for (int i = 0; i < WIDTH; i++) mid_p_d[i] = up_in_gp[i].p;
  end

  if (PIPE_STAGES >= 2) begin : g_mid_reg
    gp_t [WIDTH-1:0]  mid_gp_q;
    logic [WIDTH-1:0] mid_p_q;
    logic             mid_c0_q;
    logic [TAG_W-1:0] mid_tag_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mid_gp_q  <= '0;
        mid_p_q   <= '0;
        mid_c0_q  <= 1'b0;
        mid_tag_q <= '0;
      end else if (ld[MID]) begin
        mid_gp_q  <= mid_gp_d;
        mid_p_q   <= mid_p_d;
        mid_c0_q  <= up_c0;
        mid_tag_q <= up_tag;
      end
    end
    assign dn_gp  = mid_gp_q;
    assign dn_p   = mid_p_q;
    assign dn_c0  = mid_c0_q;
    assign dn_tag = mid_tag_q;
  end else begin : g_mid_thru
    assign dn_gp  = mid_gp_d;
    assign dn_p   = mid_p_d;
    assign dn_c0  = up_c0;
    assign dn_tag = up_tag;
  end

  // ---------------- carries, sum, flags ----------------
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d, ovf_d, zero_d;

  // The carry-in is folded in after the prefix: c[i+1] = G[0..i] | P[0..i]&c0.
  always_comb begin
    carry[0] = dn_c0;
    for (int i = 0; i < WIDTH; i++)
      carry[i+1] = prefix_gp[i].g | (prefix_gp[i].p & dn_c0);
    sum_d  = dn_p ^ carry[WIDTH-1:0];
    cout_d = carry[WIDTH];
    ovf_d  = carry[WIDTH] ^ carry[WIDTH-1];
    zero_d = ~|sum_d;
  end

  logic [WIDTH-1:0] out_sum_q;
  logic             out_cout_q, out_ovf_q, out_zero_q;
  logic [TAG_W-1:0] out_tag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum_q  <= '0;
      out_cout_q <= 1'b0;
      out_ovf_q  <= 1'b0;
      out_zero_q <= 1'b0;
      out_tag_q  <= '0;
    end else if (ld[LAST]) begin
      out_sum_q  <= sum_d;
      out_cout_q <= cout_d;
      out_ovf_q  <= ovf_d;
      out_zero_q <= zero_d;
      out_tag_q  <= dn_tag;
    end
  end

  assign out_sum  = out_sum_q;
  assign out_cout = out_cout_q;
  assign out_ovf  = out_ovf_q;
  assign out_zero = out_zero_q;
  assign out_tag  = out_tag_q;

endmodule
